rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_MAX, 3, consecutive cycles B may be stalled by A before B is forced through (legal 1..7).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: a_valid in 1, a_addr in 5, a_data in 32 -- requester A (main pipeline writeback).
REQ-005 SHALL have port: a_ready  out  1  A's write accepted this cycle.
REQ-006 SHALL have ports: b_valid in 1, b_addr in 5, b_data in 32 -- requester B (long-latency unit: load/mul/div).
REQ-007 SHALL have port: b_ready  out  1  B's write accepted this cycle.
REQ-008 SHALL have ports: rf_we out 1, rf_waddr out 5, rf_wdata out 32 -- registered drive of the register-file write port.
REQ-009 SHALL have port: pend_mask  out  32  one bit per architectural register with a write outstanding.
REQ-010 SHALL have port: b_forced  out  1  current B grant caused by starvation (debug/perf).

Function
REQ-011 SHALL accept at most one request per cycle; handshake = valid && ready in the same cycle.
REQ-012 SHALL drive a_ready/b_ready combinationally from valids and state; ready never asserted without matching valid.
REQ-013 SHALL keep a starvation counter, width 3 bits: +1 (saturating at STARVE_MAX) each cycle b_valid && !b_ready; cleared to 0 on B handshake or when b_valid low.
REQ-014 SHALL arbitrate in two states: NORMAL (counter < STARVE_MAX) and FORCE_B (counter == STARVE_MAX).
REQ-015 SHALL in NORMAL grant A when a_valid, else B when b_valid.
REQ-016 SHALL in FORCE_B grant B when b_valid (A stalled, b_forced=1), else A; FORCE_B returns to NORMAL the cycle after the B handshake.
REQ-017 SHALL register the granted request: cycle N handshake -> cycle N+1 rf_we=1, rf_waddr/rf_wdata = granted addr/data; fixed latency 1.
REQ-018 SHALL drive rf_we=0 in any cycle following no handshake; rf_waddr/rf_wdata hold last value.
REQ-019 SHALL accept writes to address 0 (ready asserted normally) but never assert rf_we for them.
REQ-020 SHALL form pend_mask = onehot(a_addr) if a_valid | onehot(b_addr) if b_valid | onehot(rf_waddr) if rf_we; bit 0 always 0.
REQ-021 SHALL be address-agnostic: same-address A/B collisions follow REQ-015/016 only; write ordering is upstream's responsibility.
REQ-022 SHALL tolerate valid withdrawn without handshake: no state change beyond REQ-013.
REQ-023 SHALL sustain one write per cycle with back-to-back grants, no bubbles.

Reset
REQ-024 SHALL on resetn low, immediately and asynchronously: rf_we=0, rf_waddr=0, rf_wdata=0, counter=0, state NORMAL, b_forced=0.
REQ-025 SHALL hold a_ready=b_ready=0 while resetn low; a handshake registered but not yet written is discarded.
REQ-026 SHALL resume arbitration on the first rising edge after resetn deasserts.

Verification
REQ-027 SHALL cover: A only, a_addr=5, a_data=0x1234_5678 at cycle N -> a_ready=1 at N; rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678 at N+1.
REQ-028 SHALL cover: A and B valid continuously, STARVE_MAX=3 -> grants A,A,A,B(b_forced=1),A,A,A,B... repeating.
REQ-029 SHALL cover: B only, b_addr=0 -> b_ready=1, rf_we stays 0, pend_mask=0.
REQ-030 SHALL cover: a_valid addr 3, b_valid addr 7, prior write addr 9 in flight -> pend_mask=0x0000_0288.
REQ-031 SHALL cover: resetn pulled low mid-cycle after handshake -> rf_we falls to 0 without clock edge, counter 0; no write emitted after release.
REQ-032 SHALL cover: random valid traffic 10k cycles -> every handshake produces exactly one rf_we (addr != 0) with matching addr/data one cycle later; B never waits > STARVE_MAX+1 cycles.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Register-file writeback bus: two requesters (A, B) in, one RF write port
// and status out. The arbiter uses the slave side.
interface rf_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic        b_forced;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, pend_mask, b_forced
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, pend_mask, b_forced
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter: A has priority, B is forced
// through after STARVE_MAX consecutive stalled cycles. One-cycle write latency.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            resetn,
  rf_wb_arbiter_if.slave  bus
);

  typedef enum logic {NORMAL, FORCE_B} state_t;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic        grant_a;
  logic        grant_b;
  logic        hs;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        wr_en;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [31:0] mask;

  always_comb begin
    grant_b  = resetn && bus.b_valid && ((state == FORCE_B) || !bus.a_valid);
    grant_a  = resetn && bus.a_valid && !grant_b;
    hs       = grant_a || grant_b;
    sel_addr = grant_b ? bus.b_addr : bus.a_addr;
    sel_data = grant_b ? bus.b_data : bus.a_data;
    // Address 0 is accepted but is never written to the register file.
    wr_en    = hs && (sel_addr != '0);
    if (!bus.b_valid || grant_b) begin
      cnt_nxt = '0;
    end else if (cnt < SMAX) begin
      cnt_nxt = cnt + 3'd1;
    end else begin
      cnt_nxt = cnt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= NORMAL;
      cnt        <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      cnt     <= cnt_nxt;
      state   <= (cnt_nxt == SMAX) ? FORCE_B : NORMAL;
      rf_we_q <= wr_en;
      if (wr_en) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
    end
  end

  always_comb begin
    mask = '0;
    if (bus.a_valid) mask[bus.a_addr] = 1'b1;
    if (bus.b_valid) mask[bus.b_addr] = 1'b1;
    if (rf_we_q)     mask[rf_waddr_q] = 1'b1;
    mask[0] = 1'b0;
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.b_forced  = grant_b && (state == FORCE_B);
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.pend_mask = mask;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: hand table, round-robin and reset
// sequences, then random traffic against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int unsigned SM = 3;

  logic clk;
  logic resetn;
  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model state: what the RF port should show after the last edge, and how
  // many consecutive cycles the current B request has been refused.
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_wait;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ar;
    logic        br;
    logic        bf;
    logic [31:0] pend;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_wait  = 0;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
  endtask

  // One clock cycle: drive at negedge, compare 1 ns later, advance the model.
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       output logic ar, output logic br, output logic bf);
    logic        ga, gb, fz;
    logic [31:0] p;
    logic [4:0]  wa;
    @(negedge clk);
    drive(av, aa, ad, bv, ba, bd);
    #1;
    fz = bv && (m_wait >= int'(SM));
    gb = bv && (fz || !av);
    ga = av && !gb;
    p = '0;
    if (av)   p[aa] = 1'b1;
    if (bv)   p[ba] = 1'b1;
    if (m_we) p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    ar = bus.a_ready; br = bus.b_ready; bf = bus.b_forced;
    chk("a_ready",   32'(ar), 32'(ga));
    chk("b_ready",   32'(br), 32'(gb));
    chk("b_forced",  32'(bf), 32'(gb && fz));
    chk("pend_mask", bus.pend_mask, p);
    chk("rf_we",     32'(bus.rf_we), 32'(m_we));
    chk("rf_waddr",  32'(bus.rf_waddr), 32'(m_waddr));
    chk("rf_wdata",  bus.rf_wdata, m_wdata);
    wa = gb ? ba : aa;
    if ((ga || gb) && wa != 5'd0) begin
      m_we = 1'b1; m_waddr = wa; m_wdata = gb ? bd : ad;
    end else begin
      m_we = 1'b0;
    end
    if (bv && !gb) m_wait++;
    else           m_wait = 0;
  endtask

  initial begin
    logic ar, br, bf;
    logic        b_hold;
    logic [4:0]  b_a;
    logic [31:0] b_d;
    int          b_wait;

    tbl[0]  = '{1, 5'd5,  32'h1234_5678, 0, 5'd0,  32'h0,         1, 0, 0, 32'h0000_0020, 0, 5'd0,  32'h0};
    tbl[1]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 0, 32'h0000_0020, 1, 5'd5,  32'h1234_5678};
    tbl[2]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 0, 32'h0,         0, 5'd5,  32'h1234_5678};
    tbl[3]  = '{0, 5'd0,  32'h0,         1, 5'd0,  32'hDEAD_BEEF, 0, 1, 0, 32'h0,         0, 5'd5,  32'h1234_5678};
    tbl[4]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 0, 32'h0,         0, 5'd5,  32'h1234_5678};
    tbl[5]  = '{1, 5'd9,  32'h99,        0, 5'd0,  32'h0,         1, 0, 0, 32'h0000_0200, 0, 5'd5,  32'h1234_5678};
    tbl[6]  = '{1, 5'd3,  32'h33,        1, 5'd7,  32'h77,        1, 0, 0, 32'h0000_0288, 1, 5'd9,  32'h99};
    tbl[7]  = '{1, 5'd3,  32'h33,        1, 5'd7,  32'h77,        1, 0, 0, 32'h0000_0088, 1, 5'd3,  32'h33};
    tbl[8]  = '{1, 5'd3,  32'h33,        1, 5'd7,  32'h77,        1, 0, 0, 32'h0000_0088, 1, 5'd3,  32'h33};
    tbl[9]  = '{1, 5'd3,  32'h33,        1, 5'd7,  32'h77,        0, 1, 1, 32'h0000_0088, 1, 5'd3,  32'h33};
    tbl[10] = '{1, 5'd3,  32'h33,        1, 5'd7,  32'h77,        1, 0, 0, 32'h0000_0088, 1, 5'd7,  32'h77};
    tbl[11] = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 0, 32'h0000_0008, 1, 5'd3,  32'h33};
    tbl[12] = '{0, 5'd0,  32'h0,         1, 5'd31, 32'hF,         0, 1, 0, 32'h8000_0000, 0, 5'd3,  32'h33};
    tbl[13] = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 0, 32'h8000_0000, 1, 5'd31, 32'hF};

    // Reset with a pending request: readies must stay low.
    resetn = 1'b0;
    drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd6, 32'h6);
    model_reset();
    #2;
    chk("rst_a_ready", 32'(bus.a_ready), 32'h0);
    chk("rst_b_ready", 32'(bus.b_ready), 32'h0);
    chk("rst_rf_we",   32'(bus.rf_we),   32'h0);
    repeat (2) @(posedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 resetn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd, ar, br, bf);
      chk($sformatf("tbl%0d_ready", i), {29'd0, ar, br, bf}, {29'd0, tbl[i].ar, tbl[i].br, tbl[i].bf});
      chk($sformatf("tbl%0d_pend", i), bus.pend_mask, tbl[i].pend);
      chk($sformatf("tbl%0d_wr", i), {bus.rf_wdata[26:0], bus.rf_waddr},
          {tbl[i].wd[26:0], tbl[i].wa});
      chk($sformatf("tbl%0d_we", i), 32'(bus.rf_we), 32'(tbl[i].we));
    end

    // Both requesters saturated: A,A,A,B(forced) repeating.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 5'(i + 1), 32'(i), 1'b1, 5'd20, 32'hB0 + 32'(i), ar, br, bf);
      chk($sformatf("rr%0d", i), {29'd0, ar, br, bf}, (i % 4 == 3) ? 32'h3 : 32'h4);
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ar, br, bf);

    // Asynchronous reset mid-cycle after a handshake, with the counter saturated.
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, ar, br, bf);
    @(posedge clk);
    #2;
    chk("pre_rst_we", 32'(bus.rf_we), 32'h1);
    resetn = 1'b0;
    #1;
    chk("async_we",    32'(bus.rf_we),    32'h0);
    chk("async_waddr", 32'(bus.rf_waddr), 32'h0);
    chk("async_wdata", bus.rf_wdata,      32'h0);
    chk("async_ready", {30'd0, bus.a_ready, bus.b_ready}, 32'h0);
    chk("async_bf",    32'(bus.b_forced), 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 resetn = 1'b1;
    model_reset();
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, ar, br, bf);
    chk("post_rst_grant", {29'd0, ar, br, bf}, 32'h4);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ar, br, bf);

    // Random traffic; B mostly holds its request until accepted.
    b_hold = 1'b0; b_a = '0; b_d = '0; b_wait = 0;
    for (int i = 0; i < 10000; i++) begin
      logic av;
      if (!b_hold && ($urandom % 3 == 0)) begin
        b_hold = 1'b1; b_a = 5'($urandom); b_d = $urandom; b_wait = 0;
      end else if (b_hold && ($urandom % 50 == 0)) begin
        b_hold = 1'b0;
      end
      av = ($urandom % 4) != 0;
      cycle(av, 5'($urandom), $urandom, b_hold, b_a, b_d, ar, br, bf);
      if (b_hold) begin
        if (br) begin
          chk("b_wait_bound", 32'(b_wait + 1 <= int'(SM) + 1), 32'h1);
          b_hold = 1'b0;
        end else begin
          b_wait++;
        end
      end
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ar, br, bf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
